lsaddrbuf: RTL
==============

LSADDRBUF -- requirements
Module: lsaddrbuf

Interface
REQ-001 Parameter DEPTH, default 4, number of buffer entries; power of two, 2..16.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 issue_en  input  1  load/store issue queue presents an op this cycle.
REQ-005 issue_opcode  input  1  1 = store, 0 = load.
REQ-006 issue_imm  input  16  signed offset.
REQ-007 issue_rdtag  input  6  destination physical tag (loads).
REQ-008 issue_rsdata  input  32  base register value.
REQ-009 issue_rtdata  input  32  store data.
REQ-010 issue_ready  output  1  buffer can accept an op this cycle.
REQ-011 flush  input  1  branch-mispredict flush.
REQ-012 dcache_en  output  1  head entry valid, request to data cache.
REQ-013 dcache_we  output  1  head entry is a store.
REQ-014 dcache_addr  output  32  head effective address.
REQ-015 dcache_wdata  output  32  head store data; zero for loads.
REQ-016 dcache_rdtag  output  6  head destination tag; zero for stores.
REQ-017 dcache_misalign  output  1  head address has addr[1:0] != 0.
REQ-018 dcache_ready  input  1  cache accepts the head request this cycle.
REQ-019 count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-020 Enqueue occurs when issue_en && issue_ready && !flush.
REQ-021 Effective address = issue_rsdata + sign-extended issue_imm, modulo 2^32, computed before storage.
REQ-022 Misalign flag = (effective address[1:0] != 0), stored per entry; misaligned ops are still issued, not dropped.
REQ-023 issue_ready = (count < DEPTH); combinational from count only, never from issue_en or dcache_ready.
REQ-024 Dequeue occurs when dcache_en && dcache_ready && !flush.
REQ-025 Strict in-order FIFO; head is the oldest entry.
REQ-026 Enqueue-to-dcache_en latency: one cycle when empty; no bypass of an empty buffer.
REQ-027 dcache_* outputs driven directly from head entry registers; constant while dcache_en && !dcache_ready.
REQ-028 Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
REQ-029 Full: issue_ready low, so no enqueue that cycle, even if the head dequeues in the same cycle.
REQ-030 Empty: dcache_en low; dcache_we, addr, wdata, rdtag and misalign all zero.
REQ-031 Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-032 flush: next cycle count = 0, pointers = 0 and all entries invalid; overrides enqueue and dequeue in the same cycle.
REQ-033 issue_en while issue_ready is low: op ignored, no state change.

Reset
REQ-034 reset low: immediately, without waiting for a clock edge, count = 0, pointers = 0, all valid bits = 0, dcache_en = 0, all dcache_* outputs = 0 and issue_ready = 1.
REQ-035 Reset asserted mid-operation discards all entries; no partial request remains after release.
REQ-036 Entry data registers need not be reset; valid bits and pointers must be.

Structure
REQ-037 Shared package holds: TAG_W = 6, DATA_W = 32, IMM_W = 16, opcode encodings LS_LOAD = 0 and LS_STORE = 1, and the entry record type (opcode, addr, wdata, rdtag, misalign).
REQ-038 One sub-module, lsagen: combinational sign-extend, add and misalign detect; instanced once at the enqueue port.
REQ-039 Storage is a register array indexed by head/tail pointers; no RAM macro.

Verification
REQ-040 Address gen: rsdata = 0x00001000, imm = 0xFFFC -> dcache_addr = 0x00000FFC, misalign = 0, one cycle later.
REQ-041 Wrap and misalign: rsdata = 0xFFFFFFFE, imm = 0x0003 -> dcache_addr = 0x00000001, misalign = 1.
REQ-042 Fill: 4 enqueues with dcache_ready = 0 -> count = 4, issue_ready = 0; a fifth issue_en is ignored; head stays the first op.
REQ-043 Full with dcache_ready = 1 and issue_en = 1 -> that cycle one dequeue and no enqueue; count = 3, then enqueue resumes.
REQ-044 Flush with 3 entries plus a concurrent issue_en -> next cycle count = 0, dcache_en = 0, issue_ready = 1.
REQ-045 Async reset pulsed between clock edges with 2 entries -> dcache_en = 0 and count = 0 before the next edge; store order after reset is preserved.

Source files
------------

// File: rtl/lsaddrbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsaddrbuf_pkg
// Brief    : Shared widths, opcode encodings and entry record for lsaddrbuf.
// Revision : 1.0 - initial release
// ============================================================================
package lsaddrbuf_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;

    typedef enum logic {
        LS_LOAD  = 1'b0,
        LS_STORE = 1'b1
    } ls_op_e;

    typedef struct packed {
        ls_op_e              opcode;
        logic [DATA_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [TAG_W-1:0]    rdtag;
        logic                misalign;
    } ls_entry_t;

endpackage
`default_nettype wire

// File: rtl/lsaddrbuf_lsagen.sv
`default_nettype none
// ============================================================================
// Module   : lsagen
// Brief    : Effective-address generator: base + sign-extended offset, plus
//            word-misalignment detect.
// Revision : 1.0 - initial release
// ============================================================================
module lsagen
    import lsaddrbuf_pkg::*;
(
    input  logic [DATA_W-1:0] rsdata,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] addr,
    output logic              misalign
);

    logic [DATA_W-1:0] w_imm_sext;

    assign w_imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign addr       = rsdata + w_imm_sext;
    assign misalign   = |addr[1:0];

endmodule
`default_nettype wire

// File: rtl/lsaddrbuf.sv
`default_nettype none
// ============================================================================
// Module   : lsaddrbuf
// Brief    : In-order load/store address buffer between the LS issue queue
//            and the data cache.
// Revision : 1.0 - initial release
// ============================================================================
module lsaddrbuf
    import lsaddrbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_en,
    input  logic                      issue_opcode,
    input  logic [IMM_W-1:0]          issue_imm,
    input  logic [TAG_W-1:0]          issue_rdtag,
    input  logic [DATA_W-1:0]         issue_rsdata,
    input  logic [DATA_W-1:0]         issue_rtdata,
    output logic                      issue_ready,
    input  logic                      flush,
    output logic                      dcache_en,
    output logic                      dcache_we,
    output logic [DATA_W-1:0]         dcache_addr,
    output logic [DATA_W-1:0]         dcache_wdata,
    output logic [TAG_W-1:0]          dcache_rdtag,
    output logic                      dcache_misalign,
    input  logic                      dcache_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    ls_entry_t          r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic [DATA_W-1:0]  w_agen_addr;
    logic               w_agen_misalign;
    ls_entry_t          w_new;
    ls_entry_t          w_head;
    logic               w_enq;
    logic               w_deq;

    lsagen u_lsagen (
        .rsdata   (issue_rsdata),
        .imm      (issue_imm),
        .addr     (w_agen_addr),
        .misalign (w_agen_misalign)
    );

    // Unused fields are zeroed at capture so the head mux needs no opcode decode.
    always_comb begin
        w_new          = '0;
        w_new.opcode   = ls_op_e'(issue_opcode);
        w_new.addr     = w_agen_addr;
        w_new.wdata    = issue_opcode ? issue_rtdata : '0;
        w_new.rdtag    = issue_opcode ? '0 : issue_rdtag;
        w_new.misalign = w_agen_misalign;
    end

    assign issue_ready = (r_count < c_full);
    assign dcache_en   = r_valid[r_head];
    assign w_enq       = issue_en && issue_ready && !flush;
    assign w_deq       = dcache_en && dcache_ready && !flush;
    assign count       = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Enqueue needs not-full and dequeue needs not-empty, so the two
            // indices can never collide in one cycle.
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= w_new;
        end
    end

    assign w_head          = r_mem[r_head];
    assign dcache_we       = dcache_en & (w_head.opcode == LS_STORE);
    assign dcache_addr     = dcache_en ? w_head.addr  : '0;
    assign dcache_wdata    = dcache_en ? w_head.wdata : '0;
    assign dcache_rdtag    = dcache_en ? w_head.rdtag : '0;
    assign dcache_misalign = dcache_en & w_head.misalign;

endmodule
`default_nettype wire
